// File: rtl/fp32_arb_pkg.sv
// Shared definitions for the fp32 adder arbiter: FSM encoding, default
// requester count and the grant-index width helper.
package fp32_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DELIVER  = 2'd3
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp32_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from the slot after last_grant, wrapping around.
module fp32_rr_pick
  import fp32_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  localparam int GW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               any_valid
);

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
    return GW'((int'(base) + off) % NUM_REQ);
  endfunction

  // Scan from farthest to nearest so the nearest asserted slot wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap_idx(last_grant, k)]) begin
        grant     = wrap_idx(last_grant, k);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp32_add_arbiter.sv
// Shares one fp32 adder among NUM_REQ requesters with round-robin grant and a
// single operation in flight; operand and result bits pass through untouched.
module fp32_add_arbiter
  import fp32_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_STB,
  output logic [NUM_REQ-1:0]    req_BUSY,
  output logic [31:0]           rsp_sum,
  output logic [NUM_REQ-1:0]    rsp_STB,
  input  logic [NUM_REQ-1:0]    rsp_BUSY,
  output logic [31:0]           adder_a,
  output logic [31:0]           adder_b,
  output logic                  adder_input_STB,
  input  logic                  adder_BUSY,
  input  logic [31:0]           adder_sum,
  input  logic                  adder_output_STB,
  output logic                  adder_output_module_BUSY
);

  localparam int GW = idx_width(NUM_REQ);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  arb_state_t           state_reg, state_next;
  logic [GW-1:0]        grant_reg, grant_next;
  logic [GW-1:0]        last_grant_reg, last_grant_next;
  logic [31:0]          a_reg, a_next;
  logic [31:0]          b_reg, b_next;
  logic                 in_stb_reg, in_stb_next;
  logic [31:0]          sum_reg, sum_next;
  logic [NUM_REQ-1:0]   rsp_stb_reg, rsp_stb_next;

  logic [GW-1:0]        pick_grant;
  logic                 pick_valid;
  logic [31:0]          op_a [NUM_REQ];
  logic [31:0]          op_b [NUM_REQ];

  fp32_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_STB),
    .last_grant (last_grant_reg),
    .grant      (pick_grant),
    .any_valid  (pick_valid)
  );

  // Only the current winner sees BUSY low, and only while idle.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_a[gi]     = req_a[gi*32 +: 32];
      assign op_b[gi]     = req_b[gi*32 +: 32];
      assign req_BUSY[gi] = !((state_reg == ST_IDLE) && pick_valid &&
                              (pick_grant == GW'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= LAST_INIT;
      a_reg          <= '0;
      b_reg          <= '0;
      in_stb_reg     <= 1'b0;
      sum_reg        <= '0;
      rsp_stb_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      in_stb_reg     <= in_stb_next;
      sum_reg        <= sum_next;
      rsp_stb_reg    <= rsp_stb_next;
    end
  end

  always_comb begin
    state_next               = state_reg;
    grant_next               = grant_reg;
    last_grant_next          = last_grant_reg;
    a_next                   = a_reg;
    b_next                   = b_reg;
    in_stb_next              = in_stb_reg;
    sum_next                 = sum_reg;
    rsp_stb_next             = rsp_stb_reg;
    adder_output_module_BUSY = 1'b1;

    unique case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_next  = pick_grant;
          a_next      = op_a[pick_grant];
          b_next      = op_b[pick_grant];
          in_stb_next = 1'b1;
          state_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (in_stb_reg && !adder_BUSY) begin
          in_stb_next = 1'b0;
          state_next  = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        adder_output_module_BUSY = 1'b0;
        if (adder_output_STB) begin
          sum_next                = adder_sum;
          rsp_stb_next            = '0;
          rsp_stb_next[grant_reg] = 1'b1;
          state_next              = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        // Result is held indefinitely until the granted requester takes it.
        if (!rsp_BUSY[grant_reg]) begin
          rsp_stb_next    = '0;
          last_grant_next = grant_reg;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign adder_a         = a_reg;
  assign adder_b         = b_reg;
  assign adder_input_STB = in_stb_reg;
  assign rsp_sum         = sum_reg;
  assign rsp_STB         = rsp_stb_reg;

endmodule

// File: doc/fp32_add_arbiter.md
FP32_ADD_ARBITER -- requirements
Module: fp32_add_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one adder_fp32 instance.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_a  in  NUM_REQ*32  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*32  operand B; slice i belongs to requester i.
- req_STB  in  NUM_REQ  request valid per requester.
- req_BUSY  out  NUM_REQ  arbiter cannot accept requester i.
- rsp_sum  out  32  result, shared by all requesters.
- rsp_STB  out  NUM_REQ  result valid for requester i.
- rsp_BUSY  in  NUM_REQ  requester i cannot take its result.
- adder_a  out  32  operand A to the adder.
- adder_b  out  32  operand B to the adder.
- adder_input_STB  out  1  operands valid to the adder.
- adder_BUSY  in  1  adder cannot accept operands.
- adder_sum  in  32  adder result.
- adder_output_STB  in  1  adder result valid.
- adder_output_module_BUSY  out  1  arbiter cannot take the adder result.

Function
REQ-003 SHALL treat every handshake as a transfer on the cycle where STB=1 and BUSY=0.
REQ-004 SHALL run FSM states IDLE, ISSUE, WAIT_RES, DELIVER, with at most one operation outstanding.
REQ-005 In IDLE: grant = first i with req_STB[i]=1, searching round-robin from (last_grant+1) mod NUM_REQ.
REQ-006 req_BUSY[i] SHALL be combinational: 0 only when state=IDLE and i=grant, so only the winner completes a transfer.
REQ-007 On an IDLE transfer: latch req_a/req_b slice of grant into adder_a/adder_b and latch grant index; next state ISSUE.
REQ-008 In ISSUE: adder_input_STB=1 (registered; asserted the cycle after acceptance).
REQ-009 ISSUE exit: on the cycle adder_input_STB=1 and adder_BUSY=0, clear adder_input_STB next cycle and go to WAIT_RES.
REQ-010 adder_output_module_BUSY SHALL be 0 only in WAIT_RES and 1 in all other states.
REQ-011 In WAIT_RES: on adder_output_STB=1, capture adder_sum into rsp_sum and go to DELIVER with rsp_STB[grant]=1.
REQ-012 In DELIVER: hold rsp_sum and rsp_STB[grant] while rsp_BUSY[grant]=1 (no timeout).
REQ-013 DELIVER exit: on the rsp_STB[grant] and !rsp_BUSY[grant] cycle, clear rsp_STB next cycle, set last_grant=grant, return to IDLE.
REQ-014 At most one rsp_STB bit SHALL be high at any time; non-granted rsp_STB bits SHALL stay 0.
REQ-015 The arbiter SHALL NOT inspect or modify operand or result bits; NaN/inf/zero are passed through unchanged.
REQ-016 Added latency over adder compute: 1 cycle accept-to-issue, plus 1 cycle capture-to-rsp_STB.
REQ-017 A requester dropping req_STB before acceptance is legal; it SHALL not be granted.

Reset
REQ-018 With rst=1 at a clock edge, the following SHALL hold next cycle, regardless of state:
- state=IDLE.
- adder_input_STB=0, rsp_STB=0, rsp_sum=0, adder_a=0, adder_b=0.
- last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-019 Reset mid-operation SHALL abandon the in-flight operation silently; the adder shares rst, so no stale result is expected after reset.

Structure
REQ-020 Shared package fp32_arb_pkg SHALL hold the FSM state encodings (2-bit) and the NUM_REQ default.
REQ-021 Round-robin selection SHALL be one combinational sub-module fp32_rr_pick:
- inputs: request vector, last_grant.
- outputs: grant index, any_valid.

Verification
REQ-022 req_STB[0] with a=0x3F800000, b=0x40000000 -> rsp_STB[0] asserted with rsp_sum=0x40400000; no other rsp_STB bit toggles.
REQ-023 req_STB[0] and req_STB[2] raised on the same cycle after reset -> requester 0 served first, then 2; each req_BUSY stays high until its own grant.
REQ-024 All four requesters continuously requesting -> grant order 0,1,2,3,0; each served exactly once per 4 operations.
REQ-025 rsp_BUSY[1]=1 held 10 cycles in DELIVER -> rsp_sum and rsp_STB[1] stable, no new acceptance; completes the cycle after rsp_BUSY drops.
REQ-026 rst pulsed during WAIT_RES -> all outputs at reset values next cycle; a following request 0x40A00000+0xC0A00000 returns 0x00000000.
